// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding single bytes to a UART transmitter through a txen/busy handshake.
// Define UART_TX_ARB_LOCK_EN to add the req_lock port, which lets a granted requester keep the channel.
module uart_tx_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        charin,
  output logic              txen,
  input  logic              busy,
  output logic [2:0]        grant_id,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] req_ready_q;
  logic [7:0]      charin_q;
  logic            txen_q;
  logic            err_q;
  logic [2:0]      grant_id_q;
  logic [2:0]      last_grant_q;
  logic [CW-1:0]   cnt_q;

  logic [NREQ-1:0] cand_s;
  logic [NREQ-1:0] ready_d;
  logic [7:0]      data_d;
  logic [2:0]      grant_d;
  logic            found_d;
  logic            take_s;
  int              dist_s;
  int              best_s;

`ifdef UART_TX_ARB_LOCK_EN
  logic            lock_q;
  logic            lock_d;
  logic            lock_hold_s;
  logic [NREQ-1:0] gmask_s;
`endif

  // Candidate masking and round-robin pick: smallest distance past last_grant wins.
  always_comb begin
    cand_s  = req_valid;
    ready_d = '0;
    data_d  = 8'h00;
    grant_d = 3'd0;
    found_d = 1'b0;
    take_s  = 1'b0;
    dist_s  = 0;
    best_s  = NREQ;
`ifdef UART_TX_ARB_LOCK_EN
    lock_d      = 1'b0;
    lock_hold_s = 1'b0;
    gmask_s     = '0;
    for (int j = 0; j < NREQ; j++) begin
      gmask_s[j]  = (grant_id_q == 3'(j));
      lock_hold_s = lock_hold_s | (lock_q & req_lock[j] & gmask_s[j]);
    end
    cand_s = lock_hold_s ? (req_valid & gmask_s) : req_valid;
`endif
    for (int j = 0; j < NREQ; j++) begin
      dist_s  = j - int'(last_grant_q) - 1;
      dist_s  = (dist_s < 0) ? dist_s + NREQ : dist_s;
      take_s  = cand_s[j] && (dist_s < best_s);
      best_s  = take_s ? dist_s : best_s;
      found_d = found_d | take_s;
      grant_d = take_s ? 3'(j) : grant_d;
      data_d  = take_s ? req_data[8*j +: 8] : data_d;
      ready_d = take_s ? ({{(NREQ-1){1'b0}}, 1'b1} << j) : ready_d;
`ifdef UART_TX_ARB_LOCK_EN
      lock_d  = take_s ? req_lock[j] : lock_d;
`endif
    end
  end

  // Main FSM; pulse outputs default low every cycle so each lasts exactly one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= '0;
      charin_q     <= 8'h00;
      txen_q       <= 1'b0;
      err_q        <= 1'b0;
      grant_id_q   <= 3'd0;
      last_grant_q <= 3'(NREQ - 1);
      cnt_q        <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      txen_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
          if (!lock_hold_s) lock_q <= 1'b0;
`endif
          if (!busy && found_d) begin
            charin_q    <= data_d;
            grant_id_q  <= grant_d;
            req_ready_q <= ready_d;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q      <= lock_d;
`endif
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          txen_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!busy) begin
            last_grant_q <= grant_id_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign charin    = charin_q;
  assign txen      = txen_q;
  assign err       = err_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb; the busy line is driven step by step to mimic the transmitter.
module tb_uart_tx_arb;
  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  charin;
  logic        txen;
  logic        busy;
  logic [2:0]  grant_id;
  logic        err;
`ifdef UART_TX_ARB_LOCK_EN
  logic [3:0]  req_lock;
`endif

  int total;
  int bad;

  uart_tx_arb #(.NREQ(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .charin    (charin),
    .txen      (txen),
    .busy      (busy),
    .grant_id  (grant_id),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for a grant, check it, then play one transmitter frame of blen busy cycles.
  task automatic xfer(input string tag, input logic [2:0] exp_id, input logic [7:0] exp_data, input int blen);
    int n;
    n = 0;
    while (req_ready == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_grant_seen"}, 32'(n < 20), 32'd1);
    chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << exp_id));
    chk({tag, "_charin"}, 32'(charin), 32'(exp_data));
    chk({tag, "_grant_id"}, 32'(grant_id), 32'(exp_id));
    chk({tag, "_txen_pre"}, 32'(txen), 32'd0);
    tick();
    chk({tag, "_txen"}, 32'(txen), 32'd1);
    chk({tag, "_ready_gone"}, 32'(req_ready), 32'd0);
    busy = 1'b1;
    for (int k = 0; k < blen; k++) begin
      tick();
      chk({tag, "_txen_low"}, 32'(txen), 32'd0);
      chk({tag, "_charin_hold"}, 32'(charin), 32'(exp_data));
    end
    busy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    busy      = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;
`ifdef UART_TX_ARB_LOCK_EN
    req_lock  = 4'b0000;
`endif
    tick();
    tick();
    chk("rst_txen", 32'(txen), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_charin", 32'(charin), 32'h00);
    chk("rst_grant", 32'(grant_id), 32'd0);
    rst = 1'b0;

    // Single requester.
    req_data  = 32'h44434241;
    req_valid = 4'b0001;
    xfer("single", 3'd0, 8'h41, 3);
    req_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("single_idle_ready", 32'(req_ready), 32'd0);
      chk("single_idle_txen", 32'(txen), 32'd0);
    end

    // Full contention from reset: strict rotation 0,1,2,3,0.
    do_reset();
    req_data  = 32'hD3D2D1D0;
    req_valid = 4'b1111;
    xfer("rr0", 3'd0, 8'hD0, 2);
    xfer("rr1", 3'd1, 8'hD1, 4);
    xfer("rr2", 3'd2, 8'hD2, 2);
    xfer("rr3", 3'd3, 8'hD3, 3);
    xfer("rr4", 3'd0, 8'hD0, 2);

    // Busy held in IDLE blocks grants; requester 1 withdraws before being served.
    busy      = 1'b1;
    req_valid = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("busyhold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 4'b0100;
    req_data  = 32'h11BB2233;
    busy      = 1'b0;
    xfer("drop", 3'd2, 8'hBB, 2);
    req_valid = 4'b0000;
    tick();
    tick();

    // Timeout: busy never rises; last_grant stays 2 so requester 0 is next.
    req_valid = 4'b0001;
    req_data  = 32'h000000E5;
    begin
      int n;
      n = 0;
      while (req_ready == 4'b0000 && n < 20) begin
        tick();
        n++;
      end
      chk("to_grant_seen", 32'(n < 20), 32'd1);
      chk("to_grant_id", 32'(grant_id), 32'd0);
    end
    tick();
    chk("to_txen", 32'(txen), 32'd1);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("to_err_early", 32'(err), 32'd0);
    end
    tick();
    chk("to_err", 32'(err), 32'd1);
    tick();
    chk("to_err_gone", 32'(err), 32'd0);
    chk("to_regrant", 32'(req_ready), 32'd1);
    req_valid = 4'b0000;

    // Reset while the transmitter is mid-frame.
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h00770000;
    xfer("mid", 3'd2, 8'h77, 0);
    busy = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_charin", 32'(charin), 32'h00);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    chk("mid_rst_txen", 32'(txen), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_hold_ready", 32'(req_ready), 32'd0);
    end
    busy = 1'b0;
    tick();
    chk("mid_regrant", 32'(req_ready), 32'b0100);
    chk("mid_regrant_id", 32'(grant_id), 32'd2);
    tick();
    chk("mid_regrant_txen", 32'(txen), 32'd1);
    req_valid = 4'b0000;

`ifdef UART_TX_ARB_LOCK_EN
    // Locked requester 1 keeps the channel for three bytes despite requester 2 waiting.
    do_reset();
    req_data  = 32'h00C2C100;
    req_valid = 4'b0110;
    req_lock  = 4'b0010;
    xfer("lk1", 3'd1, 8'hC1, 2);
    xfer("lk2", 3'd1, 8'hC1, 2);
    xfer("lk3", 3'd1, 8'hC1, 2);
    req_lock = 4'b0000;
    xfer("lk_rel", 3'd2, 8'hC2, 2);
    req_valid = 4'b0000;
`endif

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
